cdb_arbiter: RTL

- Shares the single common data bus (CDB) write port between FU_NUM functional units / reservation stations.
- Each FU raises a request carrying a result word and its destination reorder-buffer (RB) index. The block grants one FU per cycle, round-robin.
- The granted result is written into the flattened per-RB data bus with its valid bit set. Reservation stations snoop that bus to resolve Qj/Qk.
- Valid bits are cleared on commit from the reorder buffer.

---
 rtl/cdb_arbiter_pkg.sv | 30 +++
 rtl/cdb_arbiter_if.sv | 36 +++
 rtl/cdb_arbiter_rr_picker.sv | 38 +++
 rtl/cdb_arbiter.sv | 106 ++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// cdb_arbiter_pkg
// Shared constants and types for the common-data-bus arbiter slice.
//   FU_NUM     : number of functional units / reservation stations requesting
//   WORD_SIZE  : result data width
//   RB_SIZE    : reorder-buffer entries (one CDB slot per entry)
//   RB_INDEX   : width of a reorder-buffer index
// Helper: fu_onehot() turns an FU index into a one-hot grant vector.
// -----------------------------------------------------------------------------
package cdb_arbiter_pkg;

  localparam int FU_NUM    = 4;
  localparam int WORD_SIZE = 32;
  localparam int RB_SIZE   = 8;
  localparam int RB_INDEX  = 3;
  localparam int FU_PTR_W  = (FU_NUM > 1) ? $clog2(FU_NUM) : 1;

  typedef logic [WORD_SIZE-1:0] word_t;
  typedef logic [RB_INDEX-1:0]  rb_idx_t;
  typedef logic [FU_NUM-1:0]    fu_vec_t;
  typedef logic [FU_PTR_W-1:0]  fu_ptr_t;

  function automatic fu_vec_t fu_onehot(input fu_ptr_t idx);
    fu_vec_t v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// -----------------------------------------------------------------------------
// cdb_arbiter_if
// Bundles the FU request side, the reorder-buffer commit side and the
// broadcast CDB outputs of the arbiter.
//   req / req_data / req_index : per-FU requests, flattened FU-major
//   commit_valid / commit_index: reorder-buffer retirement
//   grant                      : one-hot grant, one cycle wide
//   CDB_data_data_out          : flattened per-RB result data
//   CDB_data_valid_out         : per-RB valid bits
//   collision_err              : sticky overwrite-of-valid-slot flag
// Modports: master = FUs + reorder buffer, slave = arbiter.
// -----------------------------------------------------------------------------
interface cdb_arbiter_if;
  import cdb_arbiter_pkg::*;

  fu_vec_t                       req;
  logic [WORD_SIZE*FU_NUM-1:0]   req_data;
  logic [RB_INDEX*FU_NUM-1:0]    req_index;
  logic                          commit_valid;
  rb_idx_t                       commit_index;
  fu_vec_t                       grant;
  logic [WORD_SIZE*RB_SIZE-1:0]  CDB_data_data_out;
  logic [RB_SIZE-1:0]            CDB_data_valid_out;
  logic                          collision_err;

  modport master (
    output req, req_data, req_index, commit_valid, commit_index,
    input  grant, CDB_data_data_out, CDB_data_valid_out, collision_err
  );

  modport slave (
    input  req, req_data, req_index, commit_valid, commit_index,
    output grant, CDB_data_data_out, CDB_data_valid_out, collision_err
  );

endinterface

// File: rtl/cdb_arbiter_rr_picker.sv
// -----------------------------------------------------------------------------
// cdb_arbiter_rr_picker
// Combinational round-robin first-one finder: scans eff starting at rr_ptr
// and wrapping from FU_NUM-1 to 0.
//   eff    : effective request vector
//   rr_ptr : position with highest priority this cycle
//   found  : at least one request present
//   winner : index of the first set bit at or after rr_ptr (0 if none)
// -----------------------------------------------------------------------------
module cdb_arbiter_rr_picker #(
  parameter  int FU_NUM = 4,
  localparam int PTR_W  = (FU_NUM > 1) ? $clog2(FU_NUM) : 1
) (
  input  logic [FU_NUM-1:0] eff,
  input  logic [PTR_W-1:0]  rr_ptr,
  output logic              found,
  output logic [PTR_W-1:0]  winner
);

  always_comb begin
    int               pos_i;
    logic [PTR_W-1:0] pos;
    found  = 1'b0;
    winner = '0;
    pos_i  = 0;
    pos    = '0;
    for (int k = 0; k < FU_NUM; k++) begin
      pos_i = int'(rr_ptr) + k;
      if (pos_i >= FU_NUM) pos_i = pos_i - FU_NUM;
      pos = PTR_W'(pos_i);
      if (!found && eff[pos]) begin
        found  = 1'b1;
        winner = pos;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
// Shares the single CDB write port between FU_NUM functional units. One FU is
// granted per cycle, round-robin; its result lands in the CDB slot named by
// its destination RB index with the valid bit set. Reservation stations snoop
// CDB_data_* to resolve operands; the reorder buffer clears valid on commit.
//
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous, active-low reset
//   flush  : (only with CDB_ARBITER_FLUSH_EN) clears all valid bits and the
//            grant, suppressing that cycle's write
//   bus    : cdb_arbiter_if.slave (requests, commit, grant, CDB outputs)
//
// Optional feature macro: CDB_ARBITER_FLUSH_EN
// -----------------------------------------------------------------------------
module cdb_arbiter
  import cdb_arbiter_pkg::*;
(
  input  logic clk,
  input  logic reset,
`ifdef CDB_ARBITER_FLUSH_EN
  input  logic flush,
`endif
  cdb_arbiter_if.slave bus
);

  // Registered state
  fu_vec_t                      grant_p1;
  logic [WORD_SIZE*RB_SIZE-1:0] cdb_data_p1;
  logic [RB_SIZE-1:0]           cdb_valid_p1;
  logic                         collision_p1;
  fu_ptr_t                      rr_ptr_p1;

  // Arbitration (combinational)
  fu_vec_t eff_p0;
  logic    found_p0;
  fu_ptr_t winner_p0;
  word_t   win_data_p0;
  rb_idx_t win_index_p0;
  logic    flush_p0;
  logic    clash_p0;

`ifdef CDB_ARBITER_FLUSH_EN
  assign flush_p0 = flush;
`else
  assign flush_p0 = 1'b0;
`endif

  // The FU granted last cycle still shows req while it reacts to grant.
  assign eff_p0 = bus.req & ~grant_p1;

  cdb_arbiter_rr_picker #(
    .FU_NUM (FU_NUM)
  ) u_rr_picker (
    .eff    (eff_p0),
    .rr_ptr (rr_ptr_p1),
    .found  (found_p0),
    .winner (winner_p0)
  );

  always_comb begin
    win_data_p0  = bus.req_data[int'(winner_p0)*WORD_SIZE +: WORD_SIZE];
    win_index_p0 = bus.req_index[int'(winner_p0)*RB_INDEX +: RB_INDEX];
  end

  // Overwriting a live slot is an error unless that slot retires this cycle.
  assign clash_p0 = found_p0 && cdb_valid_p1[win_index_p0] &&
                    !(bus.commit_valid && (bus.commit_index == win_index_p0));

  // ---- stage boundary: arbitration -> registered grant / CDB slots ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant_p1     <= '0;
      cdb_data_p1  <= '0;
      cdb_valid_p1 <= '0;
      collision_p1 <= 1'b0;
      rr_ptr_p1    <= '0;
    end else if (flush_p0) begin
      cdb_valid_p1 <= '0;
      grant_p1     <= '0;
    end else begin
      // Commit clear first so a same-index write below overrides it.
      if (bus.commit_valid) begin
        cdb_valid_p1[bus.commit_index] <= 1'b0;
      end
      if (found_p0) begin
        grant_p1                                              <= fu_onehot(winner_p0);
        cdb_data_p1[int'(win_index_p0)*WORD_SIZE +: WORD_SIZE] <= win_data_p0;
        cdb_valid_p1[win_index_p0]                            <= 1'b1;
        rr_ptr_p1 <= (winner_p0 == fu_ptr_t'(FU_NUM - 1)) ? '0 : winner_p0 + 1'b1;
        if (clash_p0) begin
          collision_p1 <= 1'b1;
        end
      end else begin
        grant_p1 <= '0;
      end
    end
  end

  assign bus.grant              = grant_p1;
  assign bus.CDB_data_data_out  = cdb_data_p1;
  assign bus.CDB_data_valid_out = cdb_valid_p1;
  assign bus.collision_err      = collision_p1;

endmodule
